// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexed driver for a 4-digit common-anode
// seven-segment display fed by a two-digit BCD up/down counter.
// Slots: units, tens (dp = overflow), direction glyph, overflow dash.
// Inputs are snapshotted once per frame so a digit never tears mid-frame.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank tens digit when 0).
//
// state | meaning
// S0    | units digit (an[0])
// S1    | tens digit (an[1]), dp lit when overflow latched
// S2    | direction glyph 'U' / 'd' (an[2])
// S3    | overflow dash or blank (an[3])
module seg7_scan_display #(
    parameter int SCAN_BITS = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bcd0,
    input  logic [3:0] bcd1,
    input  logic       dir,
    input  logic       cout,
    input  logic       ovf_clr,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       ovf
);

    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

    localparam logic [SCAN_BITS-1:0] PRESCALE_ONE = {{(SCAN_BITS-1){1'b0}}, 1'b1};

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_UP    = 7'b1000001;
    localparam logic [6:0] GLYPH_DOWN  = 7'b0100001;
    localparam logic [6:0] GLYPH_ERR   = 7'b0000110;

    logic [SCAN_BITS-1:0] prescale;
    logic                 tick;
    state_t               state;
    state_t               state_nxt;

    logic [3:0] snap_bcd0;
    logic [3:0] snap_bcd1;
    logic       snap_dir;
    logic       snap_ovf;

    logic [3:0] an_nxt;
    logic [6:0] seg_nxt;
    logic       dp_nxt;

    assign tick = &prescale;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = GLYPH_ERR;
        endcase
        return g;
    endfunction

    // Free-running prescaler; all-ones is the slot-advance tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prescale <= '0;
        else
            prescale <= prescale + PRESCALE_ONE;
    end

    // Slot state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S0;
        else
            state <= state_nxt;
    end

    // Frame snapshot, taken on the S3->S0 tick so a whole frame sees one value set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_bcd0 <= '0;
            snap_bcd1 <= '0;
            snap_dir  <= 1'b0;
            snap_ovf  <= 1'b0;
        end else if (tick && state == S3) begin
            snap_bcd0 <= bcd0;
            snap_bcd1 <= bcd1;
            snap_dir  <= dir;
            snap_ovf  <= ovf;
        end
    end

    // Sticky overflow; a carry on the same edge as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf <= 1'b0;
        else if (cout)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end

    // Next-slot selection and per-slot display decode.
    always_comb begin
        state_nxt = state;
        an_nxt    = 4'b1111;
        seg_nxt   = GLYPH_BLANK;
        dp_nxt    = 1'b1;
        case (state)
            S0: begin
                if (tick) state_nxt = S1;
                an_nxt  = 4'b1110;
                seg_nxt = digit_glyph(snap_bcd0);
            end
            S1: begin
                if (tick) state_nxt = S2;
                an_nxt  = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
                seg_nxt = (snap_bcd1 == 4'd0) ? GLYPH_BLANK : digit_glyph(snap_bcd1);
`else
                seg_nxt = digit_glyph(snap_bcd1);
`endif
                dp_nxt  = ~snap_ovf;
            end
            S2: begin
                if (tick) state_nxt = S3;
                an_nxt  = 4'b1011;
                seg_nxt = snap_dir ? GLYPH_UP : GLYPH_DOWN;
            end
            S3: begin
                if (tick) state_nxt = S0;
                an_nxt  = 4'b0111;
                seg_nxt = snap_ovf ? GLYPH_DASH : GLYPH_BLANK;
            end
            default: begin
                state_nxt = S0;
            end
        endcase
    end

    // Registered display outputs, one clock behind the slot state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= GLYPH_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display with SCAN_BITS=2.
// Reference model: display slot and frame position derived arithmetically
// from the number of clock edges since reset.
module tb_seg7_scan_display;

    localparam int SB    = 2;
    localparam int SLOT  = 1 << SB;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] bcd0 = '0;
    logic [3:0] bcd1 = '0;
    logic       dir = 1'b0;
    logic       cout = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    seg7_scan_display #(.SCAN_BITS(SB)) dut (
        .clk(clk), .reset(reset), .bcd0(bcd0), .bcd1(bcd1), .dir(dir),
        .cout(cout), .ovf_clr(ovf_clr), .an(an), .seg(seg), .dp(dp), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         n;
    logic [3:0] m_b0, m_b1;
    logic       m_dir, m_sovf, m_ovf;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;

    function automatic logic [6:0] ref_glyph(input int d);
        logic [6:0] tab [10];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (d > 9) return 7'b0000110;
        return tab[d];
    endfunction

    always @(posedge clk or posedge reset) begin
        int slot;
        if (reset) begin
            n = 0; m_b0 = 0; m_b1 = 0; m_dir = 0; m_sovf = 0; m_ovf = 0;
            e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
        end else begin
            slot = (n / SLOT) % 4;
            e_an = ~(4'b0001 << slot);
            e_dp = 1'b1;
            case (slot)
                0: e_seg = ref_glyph(int'(m_b0));
                1: begin
`ifdef LEADING_ZERO_BLANK_EN
                    e_seg = (m_b1 == 0) ? 7'b1111111 : ref_glyph(int'(m_b1));
`else
                    e_seg = ref_glyph(int'(m_b1));
`endif
                    e_dp = !m_sovf;
                end
                2: e_seg = m_dir ? 7'b1000001 : 7'b0100001;
                default: e_seg = m_sovf ? 7'b0111111 : 7'b1111111;
            endcase
            if ((n + 1) % FRAME == 0) begin
                m_b0 = bcd0; m_b1 = bcd1; m_dir = dir; m_sovf = m_ovf;
            end
            if (cout) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            n = n + 1;
        end
    end

    // Advance to the falling edge where the frame position equals p.
    task automatic goto(input int p);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((n % FRAME) != p && k < 2 * FRAME + 2);
        if ((n % FRAME) != p) begin
            errors++;
            $display("FAIL goto: frame position %0d, wanted %0d", n % FRAME, p);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        #2;
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b expected 1111", an); end
        checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg: got %b expected 1111111", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected 1", dp); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        @(negedge clk);
        bcd0 = 4'd3; bcd1 = 4'd7; dir = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL first_an: got %b expected 1110", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL first_seg: got %b expected 1000000", seg); end
    endtask

    task automatic test_basic;
        goto(0);
        goto(2);
        checks++; if ({an, seg, dp} !== {4'b1110, 7'b0110000, 1'b1}) begin errors++; $display("FAIL basic_s0: got %b %b %b expected 1110 0110000 1", an, seg, dp); end
        goto(6);
        checks++; if ({an, seg, dp} !== {4'b1101, 7'b1111000, 1'b1}) begin errors++; $display("FAIL basic_s1: got %b %b %b expected 1101 1111000 1", an, seg, dp); end
        goto(10);
        checks++; if ({an, seg} !== {4'b1011, 7'b1000001}) begin errors++; $display("FAIL basic_s2: got %b %b expected 1011 1000001", an, seg); end
        goto(14);
        checks++; if ({an, seg} !== {4'b0111, 7'b1111111}) begin errors++; $display("FAIL basic_s3: got %b %b expected 0111 1111111", an, seg); end
    endtask

    task automatic test_no_tearing;
        goto(2);
        bcd1 = 4'd2;
        goto(6);
        checks++; if (seg !== 7'b1111000) begin errors++; $display("FAIL tear_tens_old: got %b expected 1111000", seg); end
        bcd0 = 4'd5;
        goto(2);
        checks++; if (seg !== 7'b0010010) begin errors++; $display("FAIL tear_units_new: got %b expected 0010010", seg); end
        goto(6);
        checks++; if (seg !== 7'b0100100) begin errors++; $display("FAIL tear_tens_new: got %b expected 0100100", seg); end
    endtask

    task automatic test_ovf;
        goto(8);
        cout = 1'b1;
        @(negedge clk);
        cout = 1'b0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf); end
        goto(6);
        checks++; if (dp !== 1'b0) begin errors++; $display("FAIL ovf_dp: got %b expected 0", dp); end
        goto(14);
        checks++; if (seg !== 7'b0111111) begin errors++; $display("FAIL ovf_dash: got %b expected 0111111", seg); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
    endtask

    task automatic test_ovf_same_edge;
        cout = 1'b1; ovf_clr = 1'b1;
        @(negedge clk);
        cout = 1'b0; ovf_clr = 1'b0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", ovf); end
    endtask

    task automatic test_error_glyph;
        bcd0 = 4'hC; dir = 1'b0;
        goto(0);
        goto(2);
        checks++; if (seg !== 7'b0000110) begin errors++; $display("FAIL err_glyph: got %b expected 0000110", seg); end
        goto(10);
        checks++; if (seg !== 7'b0100001) begin errors++; $display("FAIL down_glyph: got %b expected 0100001", seg); end
    endtask

    task automatic test_leading_zero;
        logic [6:0] want;
`ifdef LEADING_ZERO_BLANK_EN
        want = 7'b1111111;
`else
        want = 7'b1000000;
`endif
        bcd1 = 4'd0;
        goto(0);
        goto(6);
        checks++; if (seg !== want) begin errors++; $display("FAIL tens_zero: got %b expected %b", seg, want); end
    endtask

    task automatic test_reset_mid;
        cout = 1'b1;
        @(negedge clk);
        cout = 1'b0;
        goto(10);
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({an, seg, dp, ovf} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin errors++; $display("FAIL reset_mid: got %b %b %b %b expected 1111 1111111 1 0", an, seg, dp, ovf); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({an, seg} !== {4'b1110, 7'b1000000}) begin errors++; $display("FAIL restart_s0: got %b %b expected 1110 1000000", an, seg); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, ovf} !== {e_an, e_seg, e_dp, m_ovf}) begin
                errors++;
                $display("FAIL random[%0d]: got an=%b seg=%b dp=%b ovf=%b expected an=%b seg=%b dp=%b ovf=%b",
                         i, an, seg, dp, ovf, e_an, e_seg, e_dp, m_ovf);
            end
            if ($urandom_range(7) == 0) bcd0 = 4'($urandom_range(15));
            if ($urandom_range(7) == 0) bcd1 = 4'($urandom_range(15));
            if ($urandom_range(9) == 0) dir = 1'($urandom_range(1));
            cout    = ($urandom_range(39) == 0);
            ovf_clr = ($urandom_range(29) == 0);
        end
        cout = 1'b0; ovf_clr = 1'b0;
    endtask

    initial begin
        #1;
        test_reset;
        test_basic;
        test_no_tearing;
        test_ovf;
        test_ovf_same_edge;
        test_error_glyph;
        test_leading_zero;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Multiplexed 4-digit seven-segment display driver sitting directly downstream of the two-digit up/down BCD counter. Consumes the counter's two BCD digits, its direction and its carry/borrow pulse. Drives the board's common-anode display in a time-multiplexed scan: units, tens, a direction glyph and an overflow indicator. Each scan frame starts from a snapshot of the inputs, so a digit never tears mid-frame.

## Interface
- `SCAN_BITS`, default 17: prescaler width. Digit slot advances every 2^SCAN_BITS clocks (~763 Hz per slot at 100 MHz).
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `bcd0`  in  4  units digit from counter
- `bcd1`  in  4  tens digit from counter
- `dir`  in  1  count direction, 1 = up, 0 = down
- `cout`  in  1  counter carry/borrow, one-cycle pulse
- `ovf_clr`  in  1  synchronous clear of sticky overflow flag
- `an`  out  4  digit anodes, active-low, `an[0]` = rightmost
- `seg`  out  7  segments, active-low, `seg[6:0]` = {g,f,e,d,c,b,a}
- `dp`  out  1  decimal point, active-low
- `ovf`  out  1  sticky overflow flag, active-high

## Operation
- **Prescaler:** free-running SCAN_BITS-bit counter, wraps to 0. `tick` = prescaler all-ones.
- **Slot state machine:** 2-bit state S0→S1→S2→S3→S0, advancing only on `tick`.
- **Snapshot:** on `tick` while in S3 (entering S0), capture `bcd0`, `bcd1`, `dir` and `ovf` into snapshot registers. Only snapshot values drive the display.
- **S0:** `an`=1110, glyph of snap_bcd0, `dp`=1.
- **S1:** `an`=1101, glyph of snap_bcd1, `dp`=0 if snap_ovf else 1.
- **S2:** `an`=1011, direction glyph: 'U'=1000001 when up, 'd'=0100001 when down. `dp`=1.
- **S3:** `an`=0111, '-'=0111111 if snap_ovf else blank 1111111. `dp`=1.
- **Digit glyphs:**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10–15 display 'E'=0000110.
- **ovf flag:**
  - Set on any clock edge with `cout`=1.
  - Cleared on an edge with `ovf_clr`=1.
  - Both high on the same edge: set wins, `ovf` stays 1.
- **Reset values:** prescaler 0, state S0, all snapshots 0, `ovf`=0, `an`=1111, `seg`=1111111, `dp`=1.

## Timing
- `an`/`seg`/`dp` are registered: they reflect the current state one clock after the state changes.
  - First edge after reset release: `an`=1110, `seg`=1000000 (snapshot 0).
- Each slot is displayed for exactly 2^SCAN_BITS clocks; a frame is 4·2^SCAN_BITS clocks.
- Input-to-display latency: input changes appear from the next frame boundary onward, at most one frame plus 1 clock later.
- `ovf` output: asserted 1 clock after the `cout` edge. Reaches `dp`/'-' at the next frame snapshot.
- Reset mid-frame: all registers and outputs return to reset values immediately, without a clock edge. Scan restarts at S0.
- Prescaler wrap is mod 2^SCAN_BITS; no other counter saturates.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: in S1, when snap_bcd1 = 0, `seg`=1111111 (tens blanked). `dp` is still driven by snap_ovf.
- Undefined: S1 shows '0'=1000000 for snap_bcd1 = 0.

## Test plan
All scenarios use SCAN_BITS=2 (slot every 4 clocks, frame 16 clocks).
- Reset, hold `bcd0`=3, `bcd1`=7, `dir`=1 through one frame -> next frame: S0 `an`=1110 `seg`=0110000; S1 `an`=1101 `seg`=1111000 `dp`=1; S2 `seg`=1000001; S3 `seg`=1111111.
- Change `bcd0` 3→5 mid-frame (during S1) -> `seg` in S0 stays 0110000 until after the next S3→S0 tick, then 0010010.
- One-cycle `cout` pulse -> `ovf`=1 next edge. Following frame: S1 `dp`=0, S3 `seg`=0111111. Then `ovf_clr`=1 -> `ovf`=0.
- `cout`=1 and `ovf_clr`=1 on the same edge -> `ovf` remains 1.
- `bcd0`=4'hC, `dir`=0 -> S0 `seg`=0000110, S2 `seg`=0100001.
- Assert `reset` mid-S2, no clock -> `an`=1111, `seg`=1111111, `dp`=1, `ovf`=0 immediately.
- With/without `LEADING_ZERO_BLANK_EN`, `bcd1`=0 -> S1 `seg`=1111111 / 1000000.
